// File: rtl/wb_tlc_tx_arb_if.sv
// Bus bundle for the TX arbiter: two TLP sources, the merged TX stream and the error flag.
//   master : the environment (sources and downstream FIFO) -- drives requests, source data,
//            framing strobes and tx_afull; observes grants, merged stream and err.
//   slave  : the arbiter -- observes requests and source data, drives grants, stream and err.
interface wb_tlc_tx_arb_if;
  logic        req0;
  logic        req1;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] din0;
  logic [15:0] din1;
  logic        sop0;
  logic        eop0;
  logic        wen0;
  logic        sop1;
  logic        eop1;
  logic        wen1;
  logic        tx_afull;
  logic [15:0] dout;
  logic        dout_sop;
  logic        dout_eop;
  logic        dout_wen;
  logic        err;

  modport master (
    output req0, req1, din0, din1, sop0, eop0, wen0, sop1, eop1, wen1, tx_afull,
    input  gnt0, gnt1, dout, dout_sop, dout_eop, dout_wen, err
  );

  modport slave (
    input  req0, req1, din0, din1, sop0, eop0, wen0, sop1, eop1, wen1, tx_afull,
    output gnt0, gnt1, dout, dout_sop, dout_eop, dout_wen, err
  );
endinterface

// File: rtl/wb_tlc_tx_arb.sv
// Round-robin TLP arbiter merging a completion source (0) and a request source (1) into one
// TX stream. A grant is held for a whole packet; the granted source's words are forwarded with
// one cycle of latency. A one-cycle gap separates packets. Protocol violations and oversize
// packets raise a sticky err.
// Ports:
//   wb_clk : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : wb_tlc_tx_arb_if.slave (req/gnt, din/sop/eop/wen per source, tx_afull,
//            merged dout/dout_sop/dout_eop/dout_wen, err)
module wb_tlc_tx_arb #(
  parameter logic [11:0] MAX_WORDS = 12'd2054
) (
  input logic            wb_clk,
  input logic            rst,
  wb_tlc_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StGap} state_e;

  state_e      state_q;
  logic        last_src_q;  // 1: source 1 was served last
  logic [11:0] word_cnt_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic [15:0] dout_q;
  logic        dout_sop_q;
  logic        dout_eop_q;
  logic        dout_wen_q;
  logic        err_q;

  logic        sel_is1;
  logic [15:0] sel_din;
  logic        sel_sop;
  logic        sel_eop;
  logic        sel_wen;
  logic        oth_wen;
  logic        last_word;

  always_comb begin
    sel_is1   = (state_q == StGnt1);
    sel_din   = sel_is1 ? bus.din1 : bus.din0;
    sel_sop   = sel_is1 ? bus.sop1 : bus.sop0;
    sel_eop   = sel_is1 ? bus.eop1 : bus.eop0;
    sel_wen   = sel_is1 ? bus.wen1 : bus.wen0;
    oth_wen   = sel_is1 ? bus.wen0 : bus.wen1;
    // The word being written now would be word number MAX_WORDS.
    last_word = (word_cnt_q == (MAX_WORDS - 12'd1));
  end

  always_ff @(posedge wb_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_src_q <= 1'b1;
      word_cnt_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      dout_q     <= '0;
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_wen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Strobes are idle unless a granted state forwards a word; dout holds.
      dout_sop_q <= 1'b0;
      dout_eop_q <= 1'b0;
      dout_wen_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!bus.tx_afull && (bus.req0 || bus.req1)) begin
            word_cnt_q <= '0;
            if (bus.req0 && (!bus.req1 || last_src_q)) begin
              state_q    <= StGnt0;
              gnt0_q     <= 1'b1;
              last_src_q <= 1'b0;
            end else begin
              state_q    <= StGnt1;
              gnt1_q     <= 1'b1;
              last_src_q <= 1'b1;
            end
          end
        end
        StGnt0, StGnt1: begin
          dout_q     <= sel_din;
          dout_sop_q <= sel_sop;
          dout_eop_q <= sel_eop;
          dout_wen_q <= sel_wen;
          // Ungranted writes are dropped but flagged.
          if (oth_wen) err_q <= 1'b1;
          if (sel_wen) begin
            word_cnt_q <= word_cnt_q + 12'd1;
            if (sel_sop && (word_cnt_q != '0)) err_q <= 1'b1;
            if (sel_eop || last_word) begin
              state_q <= StGap;
              gnt0_q  <= 1'b0;
              gnt1_q  <= 1'b0;
              // Oversize packet: terminate it ourselves.
              if (!sel_eop) begin
                err_q      <= 1'b1;
                dout_eop_q <= 1'b1;
              end
            end
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.dout     = dout_q;
  assign bus.dout_sop = dout_sop_q;
  assign bus.dout_eop = dout_eop_q;
  assign bus.dout_wen = dout_wen_q;
  assign bus.err      = err_q;

endmodule

// File: doc/wb_tlc_tx_arb.md
WB_TLC_TX_ARB -- requirements
Module: wb_tlc_tx_arb

Interface
REQ-001 Parameter: MAX_WORDS, default 12'd2054, the maximum 16-bit words per TLP (6 header words plus 2x1024 data words).
REQ-002 Port: wb_clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: req0  in  1  the completion source (CplD generator) has a whole TLP ready.
REQ-005 Port: req1  in  1  the request source (MWr/MRd generator) has a whole TLP ready.
REQ-006 Port: gnt0, gnt1  out  1 each  start permission to the source; level, held for the whole packet.
REQ-007 Port: din0, din1  in  16 each  the source data words.
REQ-008 Port: sop0/eop0/wen0, sop1/eop1/wen1  in  1 each  the source framing and write-enable strobes.
REQ-009 Port: tx_afull  in  1  the downstream TX FIFO cannot accept another maximum-size packet.
REQ-010 Port: dout  out  16  the merged TX stream data.
REQ-011 Port: dout_sop, dout_eop, dout_wen  out  1 each  the merged framing and write-enable strobes.
REQ-012 Port: err  out  1  sticky protocol/timeout error flag.

Function
REQ-013 The FSM states shall be IDLE, GNT0, GNT1 and GAP.
REQ-014 IDLE: when tx_afull=0 and at least one req is high, the block shall move to GNT0 or GNT1 and assert the matching gnt on the next edge.
REQ-015 If req0 and req1 are both high in IDLE, the grant shall go to the source not served last (round-robin); after reset, source 0 is favoured.
REQ-016 In IDLE with tx_afull=1, no grant shall be issued, whatever the req inputs.
REQ-017 In GNTn, the dout* outputs shall be registered copies of dinn/sopn/eopn/wenn (1-cycle latency); the other source's inputs shall be ignored.
REQ-018 In any state other than GNTn, dout_wen, dout_sop and dout_eop shall be driven 0; dout shall hold its last value.
REQ-019 GNTn shall leave for GAP on the cycle that wenn=1 and eopn=1 are sampled; gntn shall be deasserted on that same edge.
REQ-020 GAP shall last exactly 1 cycle, with all outputs idle, then return to IDLE; back-to-back grants are therefore separated by at least 2 cycles of gnt low.
REQ-021 The last-served pointer shall update on entry to GNTn.
REQ-022 An 12-bit word counter shall clear on grant and increment on each wenn=1 in GNTn.
REQ-023 If the counter reaches MAX_WORDS without eop, the block shall set err, force dout_eop=1 with dout_wen=1 on that word, and go to GAP.
REQ-024 A wen from the ungranted source shall set err; its data shall be discarded; the current packet shall be unaffected.
REQ-025 A sop from the granted source that arrives with word count != 0 shall set err; the word shall still be forwarded.
REQ-026 err shall clear only on reset.
REQ-027 A change on tx_afull during GNTn shall not interrupt the packet in flight.
REQ-028 A req dropped before its grant shall cancel that request with no side effects.

Reset
REQ-029 While rst=1 at a clock edge, on the next edge: state=IDLE, gnt0=gnt1=0, dout=16'h0000, dout_sop=dout_eop=dout_wen=0, err=0, counter=0, last-served=source 1 (so source 0 wins first).
REQ-030 An assertion of rst mid-packet shall drop the packet immediately; no eop shall be generated.

Verification
REQ-031 Scenario: req0 alone with a 10-word TLP (sop on word 1, eop on word 10) -> gnt0 one cycle later; dout mirrors din0 with 1-cycle delay; 10 dout_wen pulses; gnt0 falls with eop.
REQ-032 Scenario: req0 and req1 held continuously, 8-word TLPs -> grants alternate 0,1,0,1; gap of >=2 cycles between grants; no interleaved words.
REQ-033 Scenario: tx_afull=1 with req1 high -> no gnt1 for 20 cycles; tx_afull falls -> gnt1 on the next edge.
REQ-034 Scenario: granted source never asserts eop, MAX_WORDS=16 -> word 16 is output with dout_eop=1; err=1; return to IDLE.
REQ-035 Scenario: wen1 pulsed while gnt0 is active -> err=1; dout carries only din0 words.
REQ-036 Scenario: rst asserted on word 4 of 10 -> all outputs 0 on the next edge; after release, a fresh req0 is granted normally.
